multi_blink: RTL
================

MULTI_BLINK -- requirements
Module: multi_blink

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent blink channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 25: width of each channel's period/duty counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port NRST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  N_CH  per-channel enable.
REQ-006 SHALL have port mode  input  2*N_CH  per-channel mode; channel i uses bits [2i+1:2i]; 00 OFF, 01 TOGGLE, 10 PULSE, 11 PWM.
REQ-007 SHALL have port period  input  N_CH*CNT_W  per-channel period P in cycles; channel i uses slice i.
REQ-008 SHALL have port duty  input  N_CH*CNT_W  per-channel PWM high time D in cycles; channel i uses slice i.
REQ-009 SHALL have port led  output  N_CH  registered per-channel LED drive.
REQ-010 SHALL have port tick  output  N_CH  registered one-cycle pulse at each channel's counter wrap.

Function
REQ-011 Each channel SHALL own an unsigned counter cnt[CNT_W], a toggle bit tgl, and registered outputs led/tick; channels never interact except via sync (REQ-025).
REQ-012 en[i]=0 or P=0 SHALL hold cnt=0, tgl=0, tick=0, led=0 on every edge.
REQ-013 Otherwise, on each edge: if cnt >= P-1 then cnt<=0, tick<=1; else cnt<=cnt+1, tick<=0.
REQ-014 The >= compare SHALL make a mid-count period reduction wrap on the next edge, never letting cnt overrun to 2^CNT_W.
REQ-015 P=1 SHALL give tick=1 on every cycle after the first enabled edge.
REQ-016 After en rises with cnt=0, the first tick SHALL appear after exactly P edges, then every P edges.
REQ-017 Mode OFF: led<=0, tgl<=0; counter and tick keep running.
REQ-018 Mode TOGGLE: on a wrap edge tgl<=~tgl, led<=~tgl; otherwise unchanged; led period = 2P.
REQ-019 Mode PULSE: led<=next value of tick (led identical to tick).
REQ-020 Mode PWM: led<=(cnt_next < D), where cnt_next is the value being loaded into cnt; D=0 gives constant 0, D>=P gives constant 1 while enabled.
REQ-021 Leaving TOGGLE SHALL clear tgl; re-entering TOGGLE starts with led=0.
REQ-022 mode, period, duty SHALL be sampled every cycle; changes take effect on the next edge without restarting cnt (except via REQ-014).
REQ-023 All outputs SHALL be flop outputs; no combinational path from inputs to led/tick.

Reset
REQ-024 NRST low SHALL asynchronously force every cnt=0, tgl=0, led=0, tick=0; counting resumes from 0 on the first edge after NRST deasserts, including when asserted mid-period.

Configuration
REQ-025 With macro MULTI_BLINK_SYNC_EN defined, an extra port sync input 1 SHALL exist; sync=1 forces, on that edge, cnt<=0, tgl<=0, tick<=0, led<=0 for all channels, overriding REQ-013/018/020.
REQ-026 Without MULTI_BLINK_SYNC_EN, the sync port and all related logic SHALL be absent; behaviour is REQ-011..024 only.

Verification (N_CH=2, CNT_W=8)
REQ-027 en0=1, TOGGLE, P=4 -> tick0 high 1 cycle every 4 cycles, first after 4 edges; led0 square wave period 8, high 4.
REQ-028 PWM, P=10: D=3 -> led high 3 of every 10 cycles; D=10 -> constant 1; D=0 -> constant 0.
REQ-029 PULSE, P=1 -> tick0=led0=1 every cycle from the first edge; en0->0 -> both 0 on next edge.
REQ-030 P=100, change to P=5 when cnt=50 -> tick on next edge, then every 5 cycles.
REQ-031 NRST pulsed low at cnt=37 with led=1 -> led/tick 0 immediately without a clock edge; first tick exactly P edges after release.
REQ-032 MULTI_BLINK_SYNC_EN defined, ch0 P=6, ch1 P=3, out of phase; sync 1 cycle -> ticks 3 edges later on ch1, 6 edges later on both channels together.

Source files
------------

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: per-channel period counter with OFF/TOGGLE/PULSE/PWM drive.
// Optional global counter restart port `sync` exists when MULTI_BLINK_SYNC_EN is defined.
module multi_blink #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 25
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic [N_CH-1:0]       en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH*CNT_W-1:0] period,
  input  logic [N_CH*CNT_W-1:0] duty,
`ifdef MULTI_BLINK_SYNC_EN
  input  logic                  sync,
`endif
  output logic [N_CH-1:0]       led,
  output logic [N_CH-1:0]       tick
);

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_TOGGLE = 2'b01,
    M_PULSE  = 2'b10,
    M_PWM    = 2'b11
  } mode_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] p, d;
    mode_e            m;
    logic             wrap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgl_q, tgl_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;

    assign p    = period[g*CNT_W +: CNT_W];
    assign d    = duty[g*CNT_W +: CNT_W];
    assign m    = mode_e'(mode[2*g +: 2]);
    // >= rather than == so a period shrunk below the current count wraps at once
    assign wrap = (cnt_q >= p - CNT_W'(1));

    always_comb begin
      cnt_d  = '0;
      tgl_d  = 1'b0;
      led_d  = 1'b0;
      tick_d = 1'b0;
`ifdef MULTI_BLINK_SYNC_EN
      if (en[g] && (p != '0) && !sync) begin
`else
      if (en[g] && (p != '0)) begin
`endif
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        tick_d = wrap;
        unique case (m)
          M_OFF: begin
            tgl_d = 1'b0;
            led_d = 1'b0;
          end
          M_TOGGLE: begin
            // led tracks tgl, so entering TOGGLE (tgl cleared elsewhere) starts with led=0
            tgl_d = wrap ? ~tgl_q : tgl_q;
            led_d = wrap ? ~tgl_q : tgl_q;
          end
          M_PULSE: begin
            tgl_d = 1'b0;
            led_d = wrap;
          end
          M_PWM: begin
            tgl_d = 1'b0;
            led_d = (cnt_d < d);
          end
          default: begin
            tgl_d = 1'b0;
            led_d = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
        cnt_q  <= '0;
        tgl_q  <= 1'b0;
        led_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tgl_q  <= tgl_d;
        led_q  <= led_d;
        tick_q <= tick_d;
      end
    end

    assign led[g]  = led_q;
    assign tick[g] = tick_q;
  end

endmodule
